// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 32;
  localparam logic [WIDTH_DEFAULT-1:0] DIV_MAX = {1'b0, {(WIDTH_DEFAULT-1){1'b1}}};

endpackage

// File: rtl/div_period_counter.sv
// Period counter with a runtime wrap limit, synchronous clear and count enable.
module div_period_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_next_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap_o       = (count_q == limit_i);
  assign count_o      = count_q;
  assign count_next_o = count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: ratio handshake, boundary-aligned ratio updates
// and a registered divided clock derived from the period counter.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             period_done,
  output logic [WIDTH-1:0] n_clks,
  output logic             clock_out
);

  localparam logic [WIDTH-1:0] DIV_LIMIT = {1'b0, {(WIDTH-1){1'b1}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pending_div_q, pending_div_d;
  logic             clock_out_q, clock_out_d;
  logic             div_err_q, div_err_d;

  logic             cnt_clr, cnt_en, cnt_wrap;
  logic [WIDTH-1:0] cnt_limit, cnt_value, cnt_next;
  logic             xfer, legal;

  // Legal ratios keep 2*div-1 inside WIDTH bits, so the limit cannot overflow.
  assign cnt_limit = (active_div_q << 1) - WIDTH'(1);
  assign legal     = (div_value != '0) && (div_value <= DIV_LIMIT);
  assign div_ready = (state_q != PEND);
  assign xfer      = div_valid && div_ready;

  div_period_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i       (clock_in),
    .rst_ni      (reset),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .limit_i     (cnt_limit),
    .count_o     (cnt_value),
    .count_next_o(cnt_next),
    .wrap_o      (cnt_wrap)
  );

  always_comb begin
    state_d       = state_q;
    active_div_d  = active_div_q;
    pending_div_d = pending_div_q;
    cnt_clr       = 1'b1;
    cnt_en        = 1'b0;
    div_err_d     = xfer && !legal;
    case (state_q)
      IDLE: begin
        if (xfer && legal) active_div_d = div_value;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          // A request on the wrap cycle still waits for the following wrap.
          if (xfer && legal) begin
            pending_div_d = div_value;
            state_d       = PEND;
          end
        end
      end
      PEND: begin
        if (!enable) begin
          active_div_d = pending_div_q;
          state_d      = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          if (cnt_wrap) begin
            active_div_d = pending_div_q;
            state_d      = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    clock_out_d = (state_d != IDLE) && (cnt_next < active_div_d);
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      active_div_q  <= WIDTH'(DEFAULT_DIV);
      pending_div_q <= '0;
      clock_out_q   <= 1'b0;
      div_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_div_q  <= active_div_d;
      pending_div_q <= pending_div_d;
      clock_out_q   <= clock_out_d;
      div_err_q     <= div_err_d;
    end
  end

  assign period_done = (state_q != IDLE) && cnt_wrap;
  assign n_clks      = cnt_value;
  assign clock_out   = clock_out_q;
  assign div_err     = div_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the divider.
module tb_clk_div_ctrl;

  localparam int W = 32;

  logic         clock_in = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] div_value;
  logic         div_valid;
  logic         div_ready;
  logic         div_err;
  logic         period_done;
  logic [W-1:0] n_clks;
  logic         clock_out;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: running flag, pending flag, ratios and period position.
  bit              m_on, m_pend, m_err;
  longint unsigned m_act, m_new, m_pos;

  always #5 clock_in = ~clock_in;

  clk_div_ctrl #(
    .WIDTH(W),
    .DEFAULT_DIV(2)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .div_value  (div_value),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_err    (div_err),
    .period_done(period_done),
    .n_clks     (n_clks),
    .clock_out  (clock_out)
  );

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_err = 0;
    m_act = 2; m_new = 0; m_pos = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input logic [W-1:0] val);
    longint unsigned x;
    bit xfer, ok, last;
    x    = val;
    xfer = v && !m_pend;
    ok   = (x != 0) && (x < (64'd1 << (W-1)));
    m_err = xfer && !ok;
    if (!m_on) begin
      if (xfer && ok) m_act = x;
      m_pos = 0;
      m_on  = en;
    end else if (!en) begin
      if (m_pend) m_act = m_new;
      m_pend = 0; m_on = 0; m_pos = 0;
    end else begin
      last = (m_pos == 2 * m_act - 1);
      if (m_pend && last) begin
        m_act = m_new; m_pend = 0; m_pos = 0;
      end else begin
        m_pos = last ? 0 : m_pos + 1;
        if (xfer && ok) begin
          m_new = x; m_pend = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    if (!reset) model_reset();
    else model_step(enable, div_valid, div_value);
    #1;
  endtask

  function automatic logic [W+3:0] obs();
    return {clock_out, period_done, div_ready, div_err, n_clks};
  endfunction

  function automatic logic [W+3:0] expv();
    logic c, d;
    c = m_on && (m_pos < m_act);
    d = m_on && (m_pos == 2 * m_act - 1);
    return {c, d, !m_pend, m_err, W'(m_pos)};
  endfunction

  task automatic test_reset();
    reset = 0; enable = 0; div_valid = 0; div_value = '0;
    model_reset();
    #1;
    checks++; if (clock_out !== 1'b0) begin failures++; $display("FAIL reset_clock_out got=%b exp=0", clock_out); end
    checks++; if (n_clks !== '0) begin failures++; $display("FAIL reset_n_clks got=%0d exp=0", n_clks); end
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_div_ready got=%b exp=1", div_ready); end
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL reset_div_err got=%b exp=0", div_err); end
    checks++; if (period_done !== 1'b0) begin failures++; $display("FAIL reset_period_done got=%b exp=0", period_done); end
    tick(); tick();
    reset = 1;
    tick();
    checks++; if (obs() !== expv()) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_default_pattern();
    enable = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      checks++; if (clock_out !== ((i % 4) < 2)) begin failures++; $display("FAIL default_clock_out i=%0d got=%b", i, clock_out); end
      checks++; if (n_clks !== W'(i % 4)) begin failures++; $display("FAIL default_n_clks i=%0d got=%0d exp=%0d", i, n_clks, i % 4); end
      checks++; if (period_done !== ((i % 4) == 3)) begin failures++; $display("FAIL default_period_done i=%0d got=%b", i, period_done); end
      tick();
    end
  endtask

  task automatic test_ratio_change();
    int hi, lo;
    for (int k = 0; k < 64 && m_pos != 1; k++) tick();
    div_valid = 1; div_value = 5;
    tick();
    div_valid = 0;
    checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL ratio_ready_drop got=%b exp=0", div_ready); end
    for (int k = 0; k < 16 && !div_ready; k++) begin
      checks++; if (obs() !== expv()) begin failures++; $display("FAIL ratio_pend got=%h exp=%h", obs(), expv()); end
      tick();
    end
    hi = 0; lo = 0;
    for (int k = 0; k < 64 && clock_out; k++) begin hi++; tick(); end
    for (int k = 0; k < 64 && !clock_out; k++) begin lo++; tick(); end
    checks++; if (hi != 5) begin failures++; $display("FAIL ratio_high_len got=%0d exp=5", hi); end
    checks++; if (lo != 5) begin failures++; $display("FAIL ratio_low_len got=%0d exp=5", lo); end
  endtask

  task automatic test_wrap_request();
    int g;
    longint unsigned old_div;
    for (int k = 0; k < 64 && m_pos != 2 * m_act - 1; k++) tick();
    old_div = m_act;
    checks++; if (period_done !== 1'b1) begin failures++; $display("FAIL wrap_align got=%b exp=1", period_done); end
    div_valid = 1; div_value = 3;
    tick();
    div_valid = 0;
    g = 1;
    for (int k = 0; k < 100 && !period_done; k++) begin
      checks++; if (obs() !== expv()) begin failures++; $display("FAIL wrap_period got=%h exp=%h", obs(), expv()); end
      tick(); g++;
    end
    checks++; if (g != int'(2 * old_div)) begin failures++; $display("FAIL wrap_old_period got=%0d exp=%0d", g, 2 * old_div); end
    g = 0;
    for (int k = 0; k < 100; k++) begin
      tick(); g++;
      if (period_done) break;
    end
    checks++; if (g != 6) begin failures++; $display("FAIL wrap_new_period got=%0d exp=6", g); end
  endtask

  task automatic test_illegal();
    logic [W-1:0] bad [2];
    int g;
    bad[0] = '0;
    bad[1] = 32'h8000_0000;
    for (int b = 0; b < 2; b++) begin
      div_valid = 1; div_value = bad[b];
      tick();
      div_valid = 0;
      checks++; if (div_err !== 1'b1) begin failures++; $display("FAIL illegal_err_pulse b=%0d got=%b exp=1", b, div_err); end
      checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL illegal_stays_run b=%0d got=%b exp=1", b, div_ready); end
      tick();
      checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear b=%0d got=%b exp=0", b, div_err); end
    end
    for (int k = 0; k < 64 && !period_done; k++) tick();
    g = 0;
    for (int k = 0; k < 100; k++) begin
      tick(); g++;
      if (period_done) break;
    end
    checks++; if (g != 6) begin failures++; $display("FAIL illegal_period_kept got=%0d exp=6", g); end
  endtask

  task automatic test_pend_disable();
    int hi, lo;
    for (int k = 0; k < 64 && m_pos != 0; k++) tick();
    div_valid = 1; div_value = 7;
    tick();
    div_valid = 0;
    enable = 0;
    tick();
    checks++; if (clock_out !== 1'b0) begin failures++; $display("FAIL pend_dis_clock_out got=%b exp=0", clock_out); end
    checks++; if (n_clks !== '0) begin failures++; $display("FAIL pend_dis_n_clks got=%0d exp=0", n_clks); end
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL pend_dis_ready got=%b exp=1", div_ready); end
    enable = 1;
    tick();
    hi = 0; lo = 0;
    for (int k = 0; k < 64 && clock_out; k++) begin hi++; tick(); end
    for (int k = 0; k < 64 && !clock_out; k++) begin lo++; tick(); end
    checks++; if (hi + lo != 14 || hi != 7) begin failures++; $display("FAIL pend_dis_period got=%0d/%0d exp=7/7", hi, lo); end
  endtask

  task automatic test_async_reset();
    int hi, lo;
    div_valid = 1; div_value = 5;
    tick();
    div_valid = 0;
    #2;
    reset = 0;
    #1;
    model_reset();
    checks++; if (obs() !== {1'b0, 1'b0, 1'b1, 1'b0, {W{1'b0}}}) begin failures++; $display("FAIL async_reset got=%h", obs()); end
    enable = 0;
    tick(); tick();
    reset = 1;
    tick();
    enable = 1;
    tick();
    hi = 0; lo = 0;
    for (int k = 0; k < 64 && clock_out; k++) begin hi++; tick(); end
    for (int k = 0; k < 64 && !clock_out; k++) begin lo++; tick(); end
    checks++; if (hi != 2 || lo != 2) begin failures++; $display("FAIL async_reset_period got=%0d/%0d exp=2/2", hi, lo); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 39) != 0);
      div_valid = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 19);
      if (r == 0)      div_value = '0;
      else if (r == 1) div_value = 32'h8000_0000 | $urandom;
      else if (r == 2) div_value = 32'hFFFF_FFFF;
      else             div_value = W'($urandom_range(1, 6));
      tick();
      checks++; if (obs() !== expv()) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv()); end
    end
    div_valid = 0;
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_ratio_change();
    test_wrap_request();
    test_illegal();
    test_pend_disable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
